// File: rtl/cpu_defs.sv
`default_nettype none
// ============================================================================
// Package : cpu_defs
// Purpose : Shared definitions for the 5-stage MIPS core: CP0 register
//           numbers, exception codes, and bit positions of the SR and Cause
//           fields.
// Revision: 1.0 - initial release
// ============================================================================
package cpu_defs;

  // CP0 register numbers
  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  // ExcCode values
  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  // SR field positions
  localparam int SR_IM_LO  = 10;
  localparam int SR_IM_HI  = 15;
  localparam int SR_EXL    = 1;
  localparam int SR_IE     = 0;

  // Cause field positions
  localparam int CAUSE_BD     = 31;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;

endpackage : cpu_defs
`default_nettype wire

// File: rtl/cp0.sv
`default_nettype none
// ============================================================================
// Module  : cp0
// Purpose : Coprocessor 0 for the exception-capable 5-stage MIPS core. Lives
//           in the M stage; holds SR, Cause, EPC and PRId, arbitrates
//           hardware interrupts against pipelined exception codes and raises
//           the flush request.
// Ports   :
//   clk        in   1   clock
//   reset      in   1   synchronous, active-high reset
//   en         in   1   mtc0 write enable
//   CP0Add     in   5   register number for mtc0/mfc0
//   CP0In      in  32   mtc0 write data
//   VPC        in  32   PC of the M-stage (victim) instruction
//   BDIn       in   1   victim sits in a branch delay slot
//   ExcCodeIn  in   5   pipelined exception code, 0 = none
//   HWInt      in   6   external interrupt lines
//   EXLClr     in   1   eret in M stage
//   CP0Out     out 32   combinational read of register CP0Add
//   EPCOut     out 32   EPC for eret redirect (with mtc0 bypass)
//   Req        out  1   combinational exception/interrupt request
// Revision: 1.0 - initial release
// ============================================================================
module cp0
  import cpu_defs::*;
#(
  parameter logic [31:0] PRID     = 32'h2022_0819,
  parameter logic [4:0]  INT_CODE = 5'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  CP0Add,
  input  logic [31:0] CP0In,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] CP0Out,
  output logic [31:0] EPCOut,
  output logic        Req
);

  // Architectural state
  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic [31:0] victim_pc;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  assign int_req = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
  assign exc_req = (ExcCodeIn != 5'd0) & ~sr_exl;
  assign Req     = int_req | exc_req;

  // A delay-slot victim restarts at the branch so the branch is re-executed.
  assign victim_pc = {VPC[31:2], 2'b00} - (BDIn ? 32'd4 : 32'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc       <= '0;
    end else begin
      cause_ip <= HWInt;
      if (Req) begin
        // Any mtc0 from the victim is dropped: it must not commit.
        sr_exl    <= 1'b1;
        cause_exc <= int_req ? INT_CODE : ExcCodeIn;
        cause_bd  <= BDIn;
        epc       <= victim_pc;
      end else begin
        if (en && CP0Add == CP0_SR) begin
          sr_im  <= CP0In[SR_IM_HI:SR_IM_LO];
          sr_exl <= CP0In[SR_EXL];
          sr_ie  <= CP0In[SR_IE];
        end
        if (en && CP0Add == CP0_EPC) begin
          epc <= CP0In;
        end
        // Placed last so eret overrides an mtc0 SR write on the EXL bit.
        if (EXLClr) begin
          sr_exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    sr_word                        = '0;
    sr_word[SR_IM_HI:SR_IM_LO]     = sr_im;
    sr_word[SR_EXL]                = sr_exl;
    sr_word[SR_IE]                 = sr_ie;

    cause_word                           = '0;
    cause_word[CAUSE_BD]                 = cause_bd;
    cause_word[CAUSE_IP_HI:CAUSE_IP_LO]  = cause_ip;
    cause_word[CAUSE_EXC_HI:CAUSE_EXC_LO] = cause_exc;
  end

  always_comb begin
    CP0Out = '0;
    case (CP0Add)
      CP0_SR:    CP0Out = sr_word;
      CP0_CAUSE: CP0Out = cause_word;
      CP0_EPC:   CP0Out = epc;
      CP0_PRID:  CP0Out = PRID;
      default:   CP0Out = '0;
    endcase
  end

  // Forward a same-cycle mtc0 EPC so an eret right behind it redirects to
  // the new value.
  assign EPCOut = (en && CP0Add == CP0_EPC) ? CP0In : epc;

endmodule : cp0
`default_nettype wire

// File: tb/tb_cp0.sv
`default_nettype none
// ============================================================================
// Module  : tb_cp0
// Purpose : Directed self-checking bench for cp0.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cp0;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [4:0]  CP0Add;
  logic [31:0] CP0In;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] CP0Out;
  logic [31:0] EPCOut;
  logic        Req;

  int vectors = 0;
  int fails   = 0;

  cp0 dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .CP0Add    (CP0Add),
    .CP0In     (CP0In),
    .VPC       (VPC),
    .BDIn      (BDIn),
    .ExcCodeIn (ExcCodeIn),
    .HWInt     (HWInt),
    .EXLClr    (EXLClr),
    .CP0Out    (CP0Out),
    .EPCOut    (EPCOut),
    .Req       (Req)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 0; CP0Add = 0; CP0In = 0; VPC = 0; BDIn = 0;
    ExcCodeIn = 0; HWInt = 0; EXLClr = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    tick();
    reset = 0;
    CP0Add = 5'd12; #1; vectors++;
    if (CP0Out !== 32'h0) begin fails++; $display("FAIL reset_sr got %h exp %h", CP0Out, 32'h0); end
    CP0Add = 5'd13; #1; vectors++;
    if (CP0Out !== 32'h0) begin fails++; $display("FAIL reset_cause got %h exp %h", CP0Out, 32'h0); end
    CP0Add = 5'd14; #1; vectors++;
    if (CP0Out !== 32'h0) begin fails++; $display("FAIL reset_epc got %h exp %h", CP0Out, 32'h0); end
    vectors++;
    if (Req !== 1'b0) begin fails++; $display("FAIL reset_req got %b exp 0", Req); end
  endtask

  task automatic test_interrupt();
    en = 1; CP0Add = 5'd12; CP0In = 32'h0000_0401;
    tick();
    en = 0; CP0In = 0;
    CP0Add = 5'd12; #1; vectors++;
    if (CP0Out !== 32'h0000_0401) begin fails++; $display("FAIL mtc0_sr got %h exp %h", CP0Out, 32'h0000_0401); end
    HWInt = 6'b000001; VPC = 32'h0000_3010; #1; vectors++;
    if (Req !== 1'b1) begin fails++; $display("FAIL int_req got %b exp 1", Req); end
    tick();
    CP0Add = 5'd13; #1; vectors++;
    if (CP0Out !== 32'h0000_0400) begin fails++; $display("FAIL int_cause got %h exp %h", CP0Out, 32'h0000_0400); end
    CP0Add = 5'd12; #1; vectors++;
    if (CP0Out !== 32'h0000_0403) begin fails++; $display("FAIL int_sr_exl got %h exp %h", CP0Out, 32'h0000_0403); end
    CP0Add = 5'd14; #1; vectors++;
    if (CP0Out !== 32'h0000_3010) begin fails++; $display("FAIL int_epc got %h exp %h", CP0Out, 32'h0000_3010); end
    vectors++;
    if (Req !== 1'b0) begin fails++; $display("FAIL int_req_masked got %b exp 0", Req); end
    // eret
    HWInt = 0; EXLClr = 1;
    tick();
    EXLClr = 0;
    CP0Add = 5'd12; #1; vectors++;
    if (CP0Out !== 32'h0000_0401) begin fails++; $display("FAIL eret_sr got %h exp %h", CP0Out, 32'h0000_0401); end
  endtask

  task automatic test_exception_bd();
    ExcCodeIn = 5'd12; VPC = 32'h0000_3020; BDIn = 1; #1; vectors++;
    if (Req !== 1'b1) begin fails++; $display("FAIL ov_req got %b exp 1", Req); end
    tick();
    ExcCodeIn = 0; BDIn = 0;
    CP0Add = 5'd13; #1; vectors++;
    if (CP0Out !== 32'h8000_0030) begin fails++; $display("FAIL ov_cause got %h exp %h", CP0Out, 32'h8000_0030); end
    CP0Add = 5'd14; #1; vectors++;
    if (CP0Out !== 32'h0000_301C) begin fails++; $display("FAIL ov_epc got %h exp %h", CP0Out, 32'h0000_301C); end
    vectors++;
    if (EPCOut !== 32'h0000_301C) begin fails++; $display("FAIL ov_epcout got %h exp %h", EPCOut, 32'h0000_301C); end
    EXLClr = 1;
    tick();
    EXLClr = 0;
  endtask

  task automatic test_priority_and_mask();
    HWInt = 6'b000001; ExcCodeIn = 5'd10; VPC = 32'h0000_3050;
    tick();
    CP0Add = 5'd13; #1; vectors++;
    if (CP0Out !== 32'h0000_0400) begin fails++; $display("FAIL prio_cause got %h exp %h", CP0Out, 32'h0000_0400); end
    CP0Add = 5'd14; #1; vectors++;
    if (CP0Out !== 32'h0000_3050) begin fails++; $display("FAIL prio_epc got %h exp %h", CP0Out, 32'h0000_3050); end
    // EXL set: interrupt plus AdEL must not request
    ExcCodeIn = 5'd4; VPC = 32'h0000_3060; #1; vectors++;
    if (Req !== 1'b0) begin fails++; $display("FAIL exl_mask_req got %b exp 0", Req); end
    tick();
    CP0Add = 5'd14; #1; vectors++;
    if (CP0Out !== 32'h0000_3050) begin fails++; $display("FAIL exl_mask_epc got %h exp %h", CP0Out, 32'h0000_3050); end
    CP0Add = 5'd13; #1; vectors++;
    if (CP0Out !== 32'h0000_0400) begin fails++; $display("FAIL exl_mask_cause got %h exp %h", CP0Out, 32'h0000_0400); end
    ExcCodeIn = 0; EXLClr = 1;
    tick();
    EXLClr = 0;
    CP0Add = 5'd12; #1; vectors++;
    if (CP0Out !== 32'h0000_0401) begin fails++; $display("FAIL exlclr_sr got %h exp %h", CP0Out, 32'h0000_0401); end
    vectors++;
    if (Req !== 1'b1) begin fails++; $display("FAIL pending_int_req got %b exp 1", Req); end
    HWInt = 0; #1; vectors++;
    if (Req !== 1'b0) begin fails++; $display("FAIL int_drop_req got %b exp 0", Req); end
  endtask

  task automatic test_mtc0_suppressed();
    en = 1; CP0Add = 5'd14; CP0In = 32'h0000_4180; ExcCodeIn = 5'd8; VPC = 32'h0000_3070;
    #1; vectors++;
    if (Req !== 1'b1) begin fails++; $display("FAIL sys_req got %b exp 1", Req); end
    tick();
    en = 0; CP0In = 0; ExcCodeIn = 0;
    CP0Add = 5'd14; #1; vectors++;
    if (CP0Out !== 32'h0000_3070) begin fails++; $display("FAIL suppress_epc got %h exp %h", CP0Out, 32'h0000_3070); end
    CP0Add = 5'd13; #1; vectors++;
    if (CP0Out !== 32'h0000_0020) begin fails++; $display("FAIL sys_cause got %h exp %h", CP0Out, 32'h0000_0020); end
  endtask

  task automatic test_epc_bypass();
    en = 1; CP0Add = 5'd14; CP0In = 32'h0000_3040; EXLClr = 1; #1; vectors++;
    if (EPCOut !== 32'h0000_3040) begin fails++; $display("FAIL epc_bypass got %h exp %h", EPCOut, 32'h0000_3040); end
    tick();
    en = 0; CP0In = 0; EXLClr = 0;
    CP0Add = 5'd14; #1; vectors++;
    if (CP0Out !== 32'h0000_3040) begin fails++; $display("FAIL epc_written got %h exp %h", CP0Out, 32'h0000_3040); end
    CP0Add = 5'd12; #1; vectors++;
    if (CP0Out !== 32'h0000_0401) begin fails++; $display("FAIL bypass_sr got %h exp %h", CP0Out, 32'h0000_0401); end
  endtask

  task automatic test_prid_and_misc();
    CP0Add = 5'd15; #1; vectors++;
    if (CP0Out !== 32'h2022_0819) begin fails++; $display("FAIL prid got %h exp %h", CP0Out, 32'h2022_0819); end
    CP0Add = 5'd3; #1; vectors++;
    if (CP0Out !== 32'h0) begin fails++; $display("FAIL other_reg got %h exp %h", CP0Out, 32'h0); end
    en = 1; CP0Add = 5'd13; CP0In = 32'hFFFF_FFFF;
    tick();
    en = 0; CP0In = 0;
    CP0Add = 5'd13; #1; vectors++;
    if (CP0Out !== 32'h0000_0020) begin fails++; $display("FAIL cause_write_ignored got %h exp %h", CP0Out, 32'h0000_0020); end
    // mtc0 SR with EXL bit set plus eret: EXLClr wins, IM/IE follow CP0In
    en = 1; CP0Add = 5'd12; CP0In = 32'h0000_8003; EXLClr = 1;
    tick();
    en = 0; CP0In = 0; EXLClr = 0;
    CP0Add = 5'd12; #1; vectors++;
    if (CP0Out !== 32'h0000_8001) begin fails++; $display("FAIL sr_exlclr_wins got %h exp %h", CP0Out, 32'h0000_8001); end
  endtask

  task automatic test_reset_mid_handler();
    ExcCodeIn = 5'd5; VPC = 32'h0000_3084;
    tick();
    ExcCodeIn = 0;
    CP0Add = 5'd12; #1; vectors++;
    if (CP0Out !== 32'h0000_8003) begin fails++; $display("FAIL ades_sr got %h exp %h", CP0Out, 32'h0000_8003); end
    reset = 1;
    tick();
    reset = 0;
    CP0Add = 5'd12; #1; vectors++;
    if (CP0Out !== 32'h0) begin fails++; $display("FAIL midreset_sr got %h exp %h", CP0Out, 32'h0); end
    CP0Add = 5'd14; #1; vectors++;
    if (CP0Out !== 32'h0) begin fails++; $display("FAIL midreset_epc got %h exp %h", CP0Out, 32'h0); end
    CP0Add = 5'd13; #1; vectors++;
    if (CP0Out !== 32'h0) begin fails++; $display("FAIL midreset_cause got %h exp %h", CP0Out, 32'h0); end
  endtask

  initial begin
    test_reset();
    test_interrupt();
    test_exception_bd();
    test_priority_and_mask();
    test_mtc0_suppressed();
    test_epc_bypass();
    test_prid_and_misc();
    test_reset_mid_handler();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule : tb_cp0
`default_nettype wire

// File: doc/cp0.md
Name: cp0

Overview:
- Coprocessor-0 for the exception-capable 5-stage MIPS core; sits in the M stage beside data memory.
- Holds SR, Cause, EPC and PRId.
- Arbitrates hardware interrupts against the exception code accumulated through the pipeline.
- Drives Req, which flushes all pipeline registers including M/W, and CP0_RD, which feeds the M/W register's CP0 read-data input.

Parameters:
- PRID, 32'h2022_0819, constant value returned when reading register 15.
- INT_CODE, 5'd0, ExcCode recorded for an interrupt.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- en  in  1  mtc0 write enable (M-stage instruction is mtc0)
- CP0Add  in  5  register number for mtc0/mfc0
- CP0In  in  32  mtc0 write data
- VPC  in  32  PC of the M-stage instruction (victim PC)
- BDIn  in  1  M-stage instruction is in a branch delay slot
- ExcCodeIn  in  5  pipelined exception code; 0 = none
- HWInt  in  6  external interrupt lines [5:0]
- EXLClr  in  1  eret in M stage
- CP0Out  out  32  combinational read of register CP0Add
- EPCOut  out  32  current EPC, for eret redirect
- Req  out  1  combinational exception/interrupt request

Behaviour:
- Reset (clk edge with reset=1): SR, Cause and EPC are cleared to 0, so CP0Out reads 0 for regs 12-14 and Req=0 (IE=0).
- SR (reg 12) stores IM=[15:10], EXL=[1], IE=[0]. All other bits read 0.
- Cause (reg 13) stores BD=[31], IP=[15:10], ExcCode=[6:2]. All other bits read 0.
- EPC (reg 14) is 32 bits. PRId (reg 15) returns PRID. Any other address reads 0.
- IntReq = |(HWInt & SR.IM) & SR.IE & ~SR.EXL.
- ExcReq = (ExcCodeIn != 0) & ~SR.EXL.
- Req = IntReq | ExcReq. Purely combinational, same cycle as its inputs.
- Interrupt has priority over exception when both hold.
- On a clk edge with Req=1:
  - EXL<=1
  - ExcCode <= IntReq ? INT_CODE : ExcCodeIn
  - BD<=BDIn
  - EPC <= BDIn ? {VPC[31:2],2'b00}-4 : {VPC[31:2],2'b00}
- Cause.IP <= HWInt every non-reset cycle, independent of Req.
- mtc0: when en=1 and Req=0, the write takes effect at the clk edge.
  - Addr 12 writes IM, EXL, IE from the corresponding CP0In bits.
  - Addr 14 writes EPC.
  - Addr 13 and other addresses: write ignored.
- Req=1 suppresses any mtc0 that cycle; the victim instruction must not commit.
- EXLClr=1 (and Req=0) clears EXL at the edge. If en also writes SR in the same cycle, EXLClr wins on the EXL bit; IM/IE still take CP0In.
- While EXL=1, Req is held at 0, so a nested exception or interrupt is impossible.
- Reads are combinational and reflect state before the edge; there is no mtc0-to-mfc0 bypass inside the block (the hazard unit stalls).
- Reset mid-handler: EXL returns to 0 and EPC to 0; no pending state survives.
- EPCOut = EPC register, or the just-written CP0In when en=1 and CP0Add=14 in the same cycle, so eret directly after mtc0 EPC redirects correctly.

Decomposition:
- Shared package (cpu_defs): register-number constants (SR=12, CAUSE=13, EPC=14, PRID=15), ExcCode constants (Int=0, AdEL=4, AdES=5, Syscall=8, RI=10, Ov=12), and the SR/Cause bit-position localparams.
- No sub-module: a single flat block holding the state registers plus the request logic.

Test Plan:
- Reset, then mtc0 SR=32'h0000_0401 (IM[10], IE) → CP0Out@12 = 32'h0000_0401. Raise HWInt=6'b000001 → Req=1 same cycle. Next cycle: Cause = 32'h0000_0400 with ExcCode 0, EXL=1, EPC=VPC=32'h0000_3010, Req=0.
- ExcCodeIn=12 (Ov) with VPC=32'h0000_3020 and BDIn=1 → Req=1. Next cycle: Cause.BD=1, ExcCode=12 (Cause=32'h8000_0030), EPC=32'h0000_301C.
- Interrupt and ExcCodeIn=10 in the same cycle → ExcCode=0, EPC=VPC.
- EXL=1 with HWInt active and ExcCodeIn=4 → Req stays 0 and state is unchanged. Then EXLClr=1 → EXL=0, and Req rises next cycle if the interrupt is still pending.
- en=1, CP0Add=14, CP0In=32'h0000_4180 together with ExcCodeIn=8 → mtc0 suppressed; EPC=VPC, not 32'h0000_4180.
- mtc0 EPC=32'h0000_3040 with EXLClr=1 in the same cycle → EPCOut=32'h0000_3040 in that cycle. Read reg 15 → PRID. Write reg 13 → Cause unchanged.
